// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
// The width constants are also used by the instruction memory and processor top.
package prog_loader_pkg;

  localparam int INSTR_W        = 25;  // 5-bit opcode plus fields
  localparam int ADDR_W         = 8;   // matches the 8-bit PC
  localparam int OPCODE_W       = 5;
  localparam int BYTES_PER_WORD = 4;   // stream bytes per instruction word
  localparam int BYTE_W         = 8;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    HDR,   // waiting for the word-count header byte
    DATA,  // collecting payload bytes of the current word
    WR,    // one-cycle instruction memory write
    CSUM,  // waiting for the checksum byte
    RUN,   // image verified, processor released
    ERR    // checksum mismatch, processor held
  } state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Byte-to-word assembler: counts payload bytes, keeps the first three bytes of
// the current little-endian word and maintains the running XOR checksum.
// The 32-bit word is {current byte, three stored bytes}, so the complete word
// is available combinationally in the same cycle the fourth byte is accepted.
module prog_loader_word_assembler
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,     // header byte accepted
  input  logic               shift,     // payload byte accepted
  input  logic [BYTE_W-1:0]  byte_in,
  output logic               word_full, // byte_in is the last byte of a word
  output logic [INSTR_W-1:0] word,      // assembled word, upper payload bits dropped
  output logic [BYTE_W-1:0]  csum
);

  localparam int LOW_W = BYTE_W * (BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] byte_cnt;
  logic [LOW_W-1:0] low_bytes;

  // Byte counter, low-byte shift register and checksum update.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath register is reset along with the control state so a
    // mid-load reset never leaves stale bytes visible on the word output.
    if (!rst_n) begin
      byte_cnt  <= '0;
      low_bytes <= '0;
      csum      <= '0;
    end else if (start) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      byte_cnt <= '0;
      csum     <= byte_in;
    end else if (shift) begin
      byte_cnt  <= byte_cnt + 1'b1;
      low_bytes <= {byte_in, low_bytes[LOW_W-1:BYTE_W]};
      csum      <= csum ^ byte_in;
    end
  end

  assign word_full = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign word      = INSTR_W'({byte_in, low_bytes});

endmodule

// File: rtl/prog_loader.sv
// Boot-time instruction loader. Consumes a header/payload/checksum byte stream,
// writes 25-bit words sequentially into instruction memory from address 0 and
// keeps the processor in reset until the image checksum has been verified.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [BYTE_W-1:0]  rx_data,
  output logic               rx_ready,
  input  logic               load_req,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err
);

  state_t              state;
  logic [ADDR_W-1:0]   n_words;      // header value; 0 encodes 256 words
  logic [ADDR_W-1:0]   word_cnt;
  logic [ADDR_W-1:0]   word_cnt_nxt;
  logic                xfer;
  logic                asm_start;
  logic                asm_shift;
  logic                word_full;
  logic [INSTR_W-1:0]  word;
  logic [BYTE_W-1:0]   csum;

  assign xfer         = rx_valid && rx_ready;
  assign asm_start    = xfer && (state == HDR);
  assign asm_shift    = xfer && (state == DATA);
  // 8-bit wrap makes "count reached N" also cover N=0 meaning 256 words.
  assign word_cnt_nxt = word_cnt + 1'b1;

  prog_loader_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (asm_start),
    .shift     (asm_shift),
    .byte_in   (rx_data),
    .word_full (word_full),
    .word      (word),
    .csum      (csum)
  );

  // Load sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HDR;
      n_words    <= '0;
      word_cnt   <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        HDR: begin
          rx_ready <= 1'b1;
          if (xfer) begin
            n_words  <= ADDR_W'(rx_data);
            word_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (xfer && word_full) begin
            rx_ready   <= 1'b0;
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt;
            imem_wdata <= word;
            state      <= WR;
          end
        end
        WR: begin
          word_cnt <= word_cnt_nxt;
          rx_ready <= 1'b1;
          state    <= (word_cnt_nxt == n_words) ? CSUM : DATA;
        end
        CSUM: begin
          if (xfer) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
              state     <= RUN;
            end else begin
              load_err <= 1'b1;
              state    <= ERR;
            end
          end
        end
        RUN: begin
          if (load_req) begin
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            rx_ready  <= 1'b1;
            state     <= HDR;
          end
        end
        ERR: begin
          if (load_req) begin
            load_err <= 1'b0;
            rx_ready <= 1'b1;
            state    <= HDR;
          end
        end
        default: begin
          rx_ready <= 1'b0;
          state    <= HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random images are built
// as word lists, serialised into the byte stream with the expected checksum,
// and the captured memory writes and final status are compared to the list.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               rx_ready;
  logic               load_req;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_hold;
  logic               load_done;
  logic               load_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]         stream[$];
  logic [31:0]        words_q[$];
  logic [INSTR_W-1:0] exp_q[$];
  bit                 exp_ok;
  int                 exp_n;

  logic [ADDR_W-1:0]  wr_addr_q[$];
  logic [INSTR_W-1:0] wr_data_q[$];
  bit                 pending_we;

  prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Instruction memory stand-in: records every write away from the clock edge.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      check("rx_ready_in_wr", {31'd0, rx_ready}, 32'd0);
    end
  end

  // Serialise words_q behind header hdr; mask corrupts the checksum byte.
  task automatic build(input logic [7:0] hdr, input logic [7:0] mask);
    logic [7:0] cs;
    logic [7:0] by;
    stream.delete();
    exp_q.delete();
    stream.push_back(hdr);
    cs = hdr;
    foreach (words_q[i]) begin
      for (int b = 0; b < 4; b++) begin
        by = 8'(words_q[i] >> (8 * b));
        stream.push_back(by);
        cs = cs ^ by;
      end
      exp_q.push_back(words_q[i][INSTR_W-1:0]);
    end
    stream.push_back(cs ^ mask);
    exp_ok = (mask == 8'h00);
    exp_n  = words_q.size();
  endtask

  task automatic random_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  task automatic clear_capture();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Offer the first 'limit' stream bytes; gaps randomises rx_valid and load_req.
  task automatic drive(input bit gaps, input int limit);
    int i;
    int cyc;
    int budget;
    bit sent;
    i = 0;
    cyc = 0;
    budget = 20 * limit + 100;
    pending_we = 1'b0;
    while (i < limit) begin
      @(negedge clk);
      if (pending_we) begin
        check("we_latency", {31'd0, imem_we}, 32'd1);
        pending_we = 1'b0;
      end
      if (gaps && ($urandom_range(1) == 0)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = stream[i];
      end
      load_req = gaps && ($urandom_range(7) == 0);
      sent = rx_valid && rx_ready;
      @(posedge clk);
      if (sent) begin
        if (i >= 1 && i <= 4 * exp_n && (i % 4) == 0) pending_we = 1'b1;
        i++;
      end
      cyc++;
      if (cyc > budget) begin
        check("drive_timeout", i, limit);
        break;
      end
    end
    @(negedge clk);
    if (pending_we) begin
      check("we_latency", {31'd0, imem_we}, 32'd1);
      pending_we = 1'b0;
    end
    rx_valid = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic verify_load(input string name);
    int nw;
    check({name, "_load_done"}, {31'd0, load_done}, {31'd0, exp_ok});
    check({name, "_load_err"},  {31'd0, load_err},  {31'd0, !exp_ok});
    check({name, "_cpu_hold"},  {31'd0, cpu_hold},  {31'd0, !exp_ok});
    check({name, "_rx_ready"},  {31'd0, rx_ready},  32'd0);
    check({name, "_n_writes"},  wr_addr_q.size(),   exp_n);
    nw = (wr_addr_q.size() < exp_n) ? wr_addr_q.size() : exp_n;
    for (int i = 0; i < nw; i++) begin
      check($sformatf("%s_addr%0d", name, i), {24'd0, wr_addr_q[i]}, i % 256);
      check($sformatf("%s_data%0d", name, i), {7'd0, wr_data_q[i]}, {7'd0, exp_q[i]});
    end
  endtask

  // Pulse load_req from RUN/ERR and confirm the return to the header state.
  task automatic reload(input string name);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check({name, "_rl_cpu_hold"},  {31'd0, cpu_hold},  32'd1);
    check({name, "_rl_load_done"}, {31'd0, load_done}, 32'd0);
    check({name, "_rl_load_err"},  {31'd0, load_err},  32'd0);
    check({name, "_rl_rx_ready"},  {31'd0, rx_ready},  32'd1);
  endtask

  task automatic run_image(input string name, input bit gaps);
    clear_capture();
    drive(gaps, stream.size());
    verify_load(name);
    reload(name);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    load_req = 1'b0;
    #12;
    check("rst_cpu_hold",   {31'd0, cpu_hold},  32'd1);
    check("rst_rx_ready",   {31'd0, rx_ready},  32'd0);
    check("rst_imem_we",    {31'd0, imem_we},   32'd0);
    check("rst_imem_addr",  {24'd0, imem_addr}, 32'd0);
    check("rst_imem_wdata", {7'd0, imem_wdata}, 32'd0);
    check("rst_load_done",  {31'd0, load_done}, 32'd0);
    check("rst_load_err",   {31'd0, load_err},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word; bits [31:25] of 0x12345678 are dropped.
    words_q = '{32'h12345678};
    build(8'd1, 8'h00);
    run_image("one_word", 1'b0);

    // Two words including an all-ones 25-bit value.
    words_q = '{32'h00000011, 32'h01FFFFFF};
    build(8'd2, 8'h00);
    run_image("two_words", 1'b0);

    // Bad checksum: 01, 00 00 00 00, 00.
    words_q = '{32'h00000000};
    build(8'd1, 8'h01);
    run_image("bad_csum", 1'b0);

    // Header 0 loads the full 256-word memory with incrementing bytes.
    words_q.delete();
    for (int i = 0; i < 256; i++) begin
      words_q.push_back({8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
    end
    build(8'd0, 8'h00);
    run_image("full_mem", 1'b0);

    // Same three-word image back-to-back and with random rx_valid gaps.
    random_words(3);
    build(8'd3, 8'h00);
    run_image("b2b", 1'b0);
    run_image("gaps", 1'b1);

    // Reset after the header and two payload bytes.
    random_words(2);
    build(8'd2, 8'h00);
    clear_capture();
    drive(1'b0, 3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cpu_hold",  {31'd0, cpu_hold},  32'd1);
    check("midrst_imem_we",   {31'd0, imem_we},   32'd0);
    check("midrst_rx_ready",  {31'd0, rx_ready},  32'd0);
    check("midrst_load_done", {31'd0, load_done}, 32'd0);
    check("midrst_n_writes",  wr_addr_q.size(),   0);
    @(negedge clk);
    rst_n = 1'b1;
    run_image("after_rst", 1'b0);

    // Random images of random length, gaps and checksum corruption.
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 8);
      random_words(n);
      build(8'(n), ($urandom_range(2) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00);
      run_image($sformatf("rand%0d", t), 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
